// File: rtl/blue_pkg.sv
// Shared definitions for the blue execution unit: opcode values and FSM states.
package blue_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_MOV  = 4'd7;
  localparam logic [3:0] OP_EXCH = 4'd8;
  localparam logic [3:0] OP_LDA  = 4'd9;
  localparam logic [3:0] OP_LDB  = 4'd10;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/blue_alu_comb.sv
// Combinational single-cycle ALU: register results and carry for ADD/SUB/OR/AND/XOR/EXCH.
module blue_alu_comb
  import blue_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] ra_o,
  output logic [WIDTH-1:0] rb_o,
  output logic             carry_o
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] diff_s;

  // Result select; the extra top bit of the difference is the borrow.
  always_comb begin
    sum_s   = {1'b0, a_i} + {1'b0, b_i};
    diff_s  = {1'b0, a_i} - {1'b0, b_i};
    ra_o    = a_i;
    rb_o    = b_i;
    carry_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        ra_o    = sum_s[WIDTH-1:0];
        carry_o = sum_s[WIDTH];
      end
      OP_SUB: begin
        ra_o    = diff_s[WIDTH-1:0];
        carry_o = ~diff_s[WIDTH];
      end
      OP_OR:   ra_o = a_i | b_i;
      OP_AND:  ra_o = a_i & b_i;
      OP_XOR:  ra_o = a_i ^ b_i;
      OP_EXCH: begin
        ra_o = b_i;
        rb_o = a_i;
      end
      default: ra_o = a_i;
    endcase
  end

endmodule

// File: rtl/blue_exec_unit.sv
// Clocked blue execution unit: RA/RB accumulators, flags, valid/ready intake and
// a bit-serial SHR that holds off new instructions while it shifts.
module blue_exec_unit
  import blue_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ins_valid,
  output logic             ins_ready,
  input  logic [3:0]       ins_op,
  input  logic [AMT_W-1:0] ins_amt,
  input  logic [WIDTH-1:0] ld_data,
  output logic [WIDTH-1:0] ra_out,
  output logic [WIDTH-1:0] rb_out,
  output logic             carry,
  output logic             zero,
  output logic             done
);

  state_e             state_q, state_d;
  logic [AMT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   ra_q, ra_d, rb_q, rb_d;
  logic               carry_q, carry_d, zero_q, zero_d;
  logic               done_q, done_d, ready_q, ready_d;
  logic               accept_s;
  logic [WIDTH-1:0]   alu_ra_s, alu_rb_s, shr_s;
  logic               alu_carry_s;

  blue_alu_comb #(.WIDTH(WIDTH)) u_alu (
    .op_i    (ins_op),
    .a_i     (ra_q),
    .b_i     (rb_q),
    .ra_o    (alu_ra_s),
    .rb_o    (alu_rb_s),
    .carry_o (alu_carry_s)
  );

  assign accept_s = ins_valid && (state_q == IDLE);
  assign shr_s    = {1'b0, ra_q[WIDTH-1:1]};

  // Next-state, register writes and flag updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          done_d = 1'b1;
          case (ins_op)
            OP_ADD, OP_SUB: begin
              ra_d    = alu_ra_s;
              carry_d = alu_carry_s;
              zero_d  = (alu_ra_s == '0);
            end
            OP_OR, OP_AND, OP_XOR, OP_EXCH: begin
              ra_d   = alu_ra_s;
              rb_d   = alu_rb_s;
              zero_d = (alu_ra_s == '0);
            end
            OP_MOV: rb_d = ra_q;
            OP_LDA: begin
              ra_d   = ld_data;
              zero_d = (ld_data == '0);
            end
            OP_LDB: rb_d = ld_data;
            OP_SHR: begin
              // A zero count behaves exactly like NOP.
              if (ins_amt != '0) begin
                state_d = SHIFT;
                cnt_d   = ins_amt;
                done_d  = 1'b0;
              end else begin
                state_d = IDLE;
              end
            end
            default: done_d = 1'b1;
          endcase
        end else begin
          done_d = 1'b0;
        end
      end
      SHIFT: begin
        ra_d   = shr_s;
        zero_d = (shr_s == '0);
        cnt_d  = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign ins_ready = ready_q;
  assign ra_out    = ra_q;
  assign rb_out    = rb_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign done      = done_q;

endmodule

// File: tb/tb_blue_exec_unit.sv
// Directed and randomized checks of blue_exec_unit against an instruction-level model.
module tb_blue_exec_unit;

  localparam int WIDTH = 16;
  localparam int AMT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             ins_valid, ins_ready;
  logic [3:0]       ins_op;
  logic [AMT_W-1:0] ins_amt;
  logic [WIDTH-1:0] ld_data, ra_out, rb_out;
  logic             carry, zero, done;

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_ra, m_rb;
  logic        m_c, m_z;

  blue_exec_unit #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_op(ins_op), .ins_amt(ins_amt), .ld_data(ld_data),
    .ra_out(ra_out), .rb_out(rb_out), .carry(carry), .zero(zero), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ra = '0; m_rb = '0; m_c = 1'b0; m_z = 1'b0;
  endtask

  // Instruction-level reference: the whole SHR is one logical shift.
  task automatic model_apply(input logic [3:0] op, input logic [3:0] amt, input logic [15:0] data);
    logic [16:0] s;
    logic [15:0] t;
    case (op)
      4'd1: begin s = {1'b0, m_ra} + {1'b0, m_rb}; m_c = s[16]; m_ra = s[15:0]; m_z = (m_ra == 0); end
      4'd2: begin m_c = (m_ra >= m_rb); m_ra = m_ra - m_rb; m_z = (m_ra == 0); end
      4'd3: begin m_ra = m_ra | m_rb; m_z = (m_ra == 0); end
      4'd4: begin m_ra = m_ra & m_rb; m_z = (m_ra == 0); end
      4'd5: begin m_ra = m_ra ^ m_rb; m_z = (m_ra == 0); end
      4'd6: if (amt != 0) begin m_ra = m_ra >> amt; m_z = (m_ra == 0); end
      4'd7: m_rb = m_ra;
      4'd8: begin t = m_ra; m_ra = m_rb; m_rb = t; m_z = (m_ra == 0); end
      4'd9: begin m_ra = data; m_z = (m_ra == 0); end
      4'd10: m_rb = data;
      default: ;
    endcase
  endtask

  task automatic check_state(input string tag);
    check({tag, "_ra"}, ra_out, m_ra);
    check({tag, "_rb"}, rb_out, m_rb);
    check({tag, "_carry"}, carry, m_c);
    check({tag, "_zero"}, zero, m_z);
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] amt, input logic [15:0] data);
    int low;
    @(negedge clk);
    check("done_idle", done, 1'b0);
    check("ready_pre", ins_ready, 1'b1);
    ins_valid = 1'b1; ins_op = op; ins_amt = amt; ld_data = data;
    @(posedge clk);
    model_apply(op, amt, data);
    @(negedge clk);
    ins_valid = 1'b0;
    low = 0;
    while (ins_ready !== 1'b1 && low < 64) begin
      check("done_busy", done, 1'b0);
      low++;
      @(negedge clk);
    end
    check("busy_cycles", low, (op == 4'd6) ? int'(amt) : 0);
    check("done_pulse", done, 1'b1);
    check_state("result");
  endtask

  initial begin
    int low;
    ins_valid = 1'b0; ins_op = '0; ins_amt = '0; ld_data = '0;
    // Reset asserted between clock edges must act immediately.
    #2 rst = 1'b1;
    #1;
    check("rst_ra", ra_out, 16'h0000);
    check("rst_rb", rb_out, 16'h0000);
    check("rst_carry", carry, 1'b0);
    check("rst_zero", zero, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready", ins_ready, 1'b1);
    #5 rst = 1'b0;
    model_reset();

    issue(4'd9, 4'd0, 16'hFFFF);
    issue(4'd10, 4'd0, 16'h0001);
    issue(4'd1, 4'd0, 16'h0000);
    check("add_ra", ra_out, 16'h0000);
    check("add_carry", carry, 1'b1);
    check("add_zero", zero, 1'b1);

    issue(4'd9, 4'd0, 16'h0003);
    issue(4'd10, 4'd0, 16'h0005);
    issue(4'd2, 4'd0, 16'h0000);
    check("sub_ra", ra_out, 16'hFFFE);
    check("sub_carry", carry, 1'b0);
    check("sub_zero", zero, 1'b0);
    issue(4'd8, 4'd0, 16'h0000);
    check("exch_ra", ra_out, 16'h0005);
    check("exch_rb", rb_out, 16'hFFFE);

    // SHR 4 with valid held and an XOR queued behind it.
    issue(4'd10, 4'd0, 16'h00F0);
    issue(4'd9, 4'd0, 16'h8000);
    @(negedge clk);
    ins_valid = 1'b1; ins_op = 4'd6; ins_amt = 4'd4; ld_data = 16'h0000;
    @(posedge clk);
    model_apply(4'd6, 4'd4, 16'h0000);
    @(negedge clk);
    ins_op = 4'd5;
    low = 0;
    while (ins_ready !== 1'b1 && low < 64) begin
      check("q_done_busy", done, 1'b0);
      low++;
      @(negedge clk);
    end
    check("q_busy_cycles", low, 4);
    check("q_shr_done", done, 1'b1);
    check("q_shr_ra", ra_out, 16'h0800);
    @(posedge clk);
    model_apply(4'd5, 4'd0, 16'h0000);
    @(negedge clk);
    ins_valid = 1'b0;
    check("q_xor_done", done, 1'b1);
    check("q_xor_ra", ra_out, 16'h08F0);
    check_state("q_xor");

    // Reset in the middle of a 9-step shift discards it.
    issue(4'd9, 4'd0, 16'hFFFF);
    @(negedge clk);
    ins_valid = 1'b1; ins_op = 4'd6; ins_amt = 4'd9;
    @(posedge clk);
    @(negedge clk);
    ins_valid = 1'b0;
    check("mid_ready", ins_ready, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_ra", ra_out, 16'h1FFF);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ra", ra_out, 16'h0000);
    check("mid_rst_rb", rb_out, 16'h0000);
    check("mid_rst_carry", carry, 1'b0);
    check("mid_rst_zero", zero, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_ready", ins_ready, 1'b1);
    #1 rst = 1'b0;
    model_reset();
    repeat (10) begin
      @(negedge clk);
      check("post_rst_done", done, 1'b0);
      check("post_rst_ready", ins_ready, 1'b1);
    end

    // Reserved opcode behaves as NOP but still completes.
    issue(4'd9, 4'd0, 16'h1234);
    issue(4'd13, 4'd7, 16'hBEEF);
    check("op13_ra", ra_out, 16'h1234);
    check("op13_zero", zero, 1'b0);

    for (int i = 0; i < 60; i++) begin
      issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
